soc_multi_timer: RTL and testbench



---
 rtl/soc_multi_timer.sv | 213 +++++++++++++++++++++
 tb/tb_soc_multi_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/soc_multi_timer.sv
// soc_multi_timer: multi-channel interval timer on an Avalon-MM slave.
//
// NUM_CH independent down-counters. Each channel has a period register, a
// prescaler and its own interrupt line. A timeout is a prescaler tick that
// finds the counter at zero. The counter then reloads from PERIOD and TO is
// set. A one-shot channel (CONT = 0) also stops.
//
// Optional build macro: SOC_MULTI_TIMER_CASCADE_EN
//   When it is defined, a channel i >= 1 with CASCADE = 1 counts the timeouts
//   of channel i-1 instead of its own prescaler ticks.
//   When it is undefined, CONTROL bit4 is not stored and reads 0.
//
// Ports:
//   clk, reset_n     clock; asynchronous active-low reset
//   address          word address: [2:0] register offset, upper bits channel
//   chipselect       slave select
//   write_n          active-low write strobe
//   writedata        write data (bits above CNT_W/PRE_W are ignored)
//   readdata         registered read data (one-cycle latency)
//   irq              per-channel interrupt = TO & ITO
//   irq_any          OR of irq
//
// Register offsets per channel:
//   0 STATUS   [0] TO, [1] RUN; any write clears TO
//   1 CONTROL  [0] ITO, [1] CONT, [2] START, [3] STOP, [4] CASCADE
//   2 PERIOD
//   3 SNAP     a write captures the live counter; a read returns the capture
//   4 PRESCALE
module soc_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(NUM_CH)+3-1:0]  address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH-1:0]            irq,
  output logic                         irq_any
);

  localparam int AW = $clog2(NUM_CH) + 3;
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

`ifdef SOC_MULTI_TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OFF_STATUS   = 3'd0,
    OFF_CONTROL  = 3'd1,
    OFF_PERIOD   = 3'd2,
    OFF_SNAP     = 3'd3,
    OFF_PRESCALE = 3'd4
  } reg_off_e;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
  logic [PRE_W-1:0]  pre_q    [NUM_CH];
  logic [PRE_W-1:0]  pre_d    [NUM_CH];
  logic [PRE_W-1:0]  pcnt_q   [NUM_CH];
  logic [PRE_W-1:0]  pcnt_d   [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, ito_q, ito_d;
  logic [NUM_CH-1:0] cont_q, cont_d, casc_q, casc_d;
  logic [NUM_CH-1:0] reload_q, reload_d;  // forced reload one clk after a PERIOD write
  logic [31:0]       rdata_q, rdata_d;

  logic [NUM_CH-1:0] tick, tmo;
  logic              prev_tmo;
  logic [AW-1:0]     ch_addr;
  reg_off_e          off;
  logic              wr_en;

  assign ch_addr = address >> 3;
  assign off     = reg_off_e'(address[2:0]);
  assign wr_en   = chipselect && !write_n;

  // NOTE: every signal driven here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    prev_tmo = 1'b0;
    tick     = '0;
    tmo      = '0;
    cnt_d    = cnt_q;
    period_d = period_q;
    snap_d   = snap_q;
    pre_d    = pre_q;
    pcnt_d   = pcnt_q;
    run_d    = run_q;
    to_d     = to_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    casc_d   = casc_q;
    reload_d = '0;
    rdata_d  = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      // A cascaded channel is clocked by the timeout of the channel below it.
      // The chain ripples combinationally from channel 0 upwards.
      if (CASC_EN && (i != 0) && casc_q[i]) begin
        tick[i] = run_q[i] && prev_tmo;
      end else begin
        tick[i] = run_q[i] && (pcnt_q[i] == pre_q[i]);
      end
      tmo[i]   = tick[i] && (cnt_q[i] == '0);
      prev_tmo = tmo[i];

      if (run_q[i]) begin
        pcnt_d[i] = (pcnt_q[i] == pre_q[i]) ? '0 : pcnt_q[i] + PRE_W'(1);
      end

      if (reload_q[i]) begin
        cnt_d[i]  = period_q[i];
        pcnt_d[i] = '0;
      end else if (tick[i]) begin
        cnt_d[i] = tmo[i] ? period_q[i] : cnt_q[i] - CNT_W'(1);
      end

      if (tmo[i] && !cont_q[i]) run_d[i] = 1'b0;

      if (wr_en && (ch_addr == AW'(i))) begin
        unique case (off)
          OFF_STATUS:  to_d[i] = 1'b0;
          OFF_CONTROL: begin
            ito_d[i]  = writedata[0];
            cont_d[i] = writedata[1];
            casc_d[i] = CASC_EN && writedata[4];
            if (writedata[2]) begin         // START wins over STOP
              run_d[i]  = 1'b1;
              pcnt_d[i] = '0;
            end else if (writedata[3]) begin
              run_d[i] = 1'b0;
            end
          end
          OFF_PERIOD: begin
            period_d[i] = writedata[CNT_W-1:0];
            run_d[i]    = 1'b0;
            reload_d[i] = 1'b1;
          end
          OFF_SNAP:     snap_d[i] = cnt_q[i];   // pre-decrement value
          OFF_PRESCALE: pre_d[i]  = writedata[PRE_W-1:0];
          default: ;
        endcase
      end

      // Setting TO overrides a same-cycle STATUS clear, so no timeout is lost.
      if (tmo[i]) to_d[i] = 1'b1;

      if (ch_addr == AW'(i)) begin
        unique case (off)
          OFF_STATUS:   rdata_d = {30'd0, run_q[i], to_q[i]};
          OFF_CONTROL:  rdata_d = {27'd0, casc_q[i], 2'b00, cont_q[i], ito_q[i]};
          OFF_PERIOD:   rdata_d = 32'(period_q[i]);
          OFF_SNAP:     rdata_d = 32'(snap_q[i]);
          OFF_PRESCALE: rdata_d = 32'(pre_q[i]);
          default:      rdata_d = '0;
        endcase
      end
    end
  end

  // NOTE: state uses non-blocking assignments so that every flop samples the
  // pre-edge values. Blocking assignments here would make results depend on
  // statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-channel arrays are plain flops, not RAM, so they can
      // and must reset. This loop gives every entry its reset value.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= RST_PERIOD;
        period_q[i] <= RST_PERIOD;
        snap_q[i]   <= '0;
        pre_q[i]    <= '0;
        pcnt_q[i]   <= '0;
      end
      run_q    <= '0;
      to_q     <= '0;
      ito_q    <= '0;
      cont_q   <= '0;
      casc_q   <= '0;
      reload_q <= '0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      to_q     <= to_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      casc_q   <= casc_d;
      reload_q <= reload_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = to_q & ito_q;
  assign irq_any  = |irq;

endmodule

// File: tb/tb_soc_multi_timer.sv
// Directed testbench for soc_multi_timer (default parameters). The expected
// values were worked out by hand from the register behaviour. Edge numbers
// in the comments count clock edges from the START write (E0).
module tb_soc_multi_timer;

  localparam int NUM_CH = 4;
  localparam int AW     = $clog2(NUM_CH) + 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  soc_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(49)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Each bus task is entered at a negedge and returns at the next negedge.
  // The access happens on the posedge in between.
  task automatic bus_wr(input int ch, input int off, input logic [31:0] d);
    address    = AW'(ch * 8 + off);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input int ch, input int off, output logic [31:0] d);
    address    = AW'(ch * 8 + off);
    chipselect = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] rd;
  logic        glitch;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #12;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_any", 32'(irq_any), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    bus_rd(0, 2, rd); check("rst_ch0_period", rd, 32'd49);
    bus_rd(0, 0, rd); check("rst_ch0_status", rd, 32'd0);

    // ch1: period 9, prescale 0, continuous: TO at E10, E20, ...
    bus_wr(1, 2, 9);
    bus_wr(1, 4, 0);
    bus_wr(1, 1, 32'h7);                      // E0
    repeat (9) @(negedge clk);
    check("ch1_irq_before_to", 32'(irq[1]), 32'd0);
    @(negedge clk);                           // after E10
    check("ch1_irq_first_to", 32'(irq[1]), 32'd1);
    check("ch1_irq_any", 32'(irq_any), 32'd1);
    bus_wr(1, 0, 0);                          // E11 clears TO
    check("ch1_irq_cleared", 32'(irq[1]), 32'd0);
    bus_rd(1, 0, rd); check("ch1_status_run", rd, 32'd2);
    bus_rd(1, 1, rd); check("ch1_control_rb", rd, 32'd3);
    repeat (7) @(negedge clk);                // after E20
    check("ch1_irq_second_to", 32'(irq[1]), 32'd1);
    bus_wr(1, 1, 32'h8);
    bus_wr(1, 0, 0);
    check("ch1_stopped_irq_any", 32'(irq_any), 32'd0);

    // ch2: period 4, prescale 3, one-shot: single TO at E20
    bus_wr(2, 2, 4);
    bus_wr(2, 4, 3);
    bus_wr(2, 1, 32'h5);                      // E0
    repeat (19) @(negedge clk);
    check("ch2_irq_before_to", 32'(irq[2]), 32'd0);
    @(negedge clk);
    check("ch2_irq_at_to", 32'(irq[2]), 32'd1);
    bus_rd(2, 0, rd); check("ch2_status_oneshot", rd, 32'd1);
    bus_wr(2, 3, 0);
    bus_rd(2, 3, rd); check("ch2_snap_reloaded", rd, 32'd4);
    bus_wr(2, 0, 0);

    // ch0: PERIOD write while running stops it and forces a reload
    bus_wr(0, 1, 32'h6);
    repeat (5) @(negedge clk);
    bus_wr(0, 2, 100);
    bus_rd(0, 0, rd); check("ch0_period_wr_stops", rd, 32'd0);
    bus_wr(0, 3, 0);
    bus_rd(0, 3, rd); check("ch0_snap_reload", rd, 32'd100);

    // ch0 restart from 100: timeout at E101, coincident with a STATUS write
    bus_wr(0, 1, 32'h6);                      // E0
    bus_rd(0, 0, rd); check("ch0_running", rd, 32'd2);   // E1
    repeat (99) @(negedge clk);
    bus_wr(0, 0, 0);                          // E101
    bus_rd(0, 0, rd); check("ch0_to_beats_clear", rd, 32'd3);  // E102
    bus_wr(0, 1, 32'hC);                      // E103: START+STOP
    bus_rd(0, 0, rd); check("ch0_start_wins", rd, 32'd3);      // E104
    bus_wr(0, 1, 32'h8);                      // E105: STOP, last tick -> 96
    bus_rd(0, 0, rd); check("ch0_stopped", rd, 32'd1);         // E106
    bus_wr(0, 3, 0);                          // E107
    bus_rd(0, 3, rd); check("ch0_snap_a", rd, 32'd96);
    repeat (3) @(negedge clk);
    bus_wr(0, 3, 0);                          // E112
    bus_rd(0, 3, rd); check("ch0_snap_b_held", rd, 32'd96);

    bus_rd(0, 5, rd); check("unused_offset5", rd, 32'd0);

    bus_wr(3, 1, 32'h10);
    bus_rd(3, 1, rd);
`ifdef SOC_MULTI_TIMER_CASCADE_EN
    check("ctrl_bit4_rw", rd, 32'h10);

    // ch0 period 3 continuous, ch1 period 1 cascaded: ch1 TO at E8
    bus_wr(0, 2, 3);
    bus_wr(1, 2, 1);
    bus_wr(1, 0, 0);
    bus_wr(1, 1, 32'h17);
    bus_wr(0, 1, 32'h6);                      // E0
    repeat (7) @(negedge clk);
    check("casc_irq_before", 32'(irq[1]), 32'd0);
    @(negedge clk);
    check("casc_irq_at_8", 32'(irq[1]), 32'd1);
`else
    check("ctrl_bit4_zero", rd, 32'd0);
`endif

    // Asynchronous reset in the middle of a count
    bus_wr(2, 1, 32'h7);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    glitch  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (irq_any) glitch = 1'b1;
    end
    check("post_rst_no_irq", 32'(glitch), 32'd0);
    bus_rd(2, 2, rd); check("post_rst_period", rd, 32'd49);
    bus_rd(2, 0, rd); check("post_rst_status", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
